rec_log_merger: RTL

Downstream of the per-channel record FIFOs. Pops all channel FIFOs in lock-step, one record at a time, and serialises each record into a single log stream for the log writer. Each record becomes one header beat followed by one payload beat per channel that holds a real packet, in ascending channel order.

---
 rtl/rec_log_pkg.sv | 25 ++
 rtl/lowest_set_idx.sv | 26 ++
 rtl/rec_log_merger.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rec_log_pkg.sv
// Shared types and header-layout helpers for the record log merger.
//   state_e       : serialiser state (header next / payload next)
//   HDR_SEQ_W     : width of the record sequence field in the header beat
//   hdr_busy_lsb  : bit offset of the busy field in the header beat
//   hdr_seq_lsb   : bit offset of the sequence field in the header beat
package rec_log_pkg;

    typedef enum logic {
        S_HDR = 1'b0,
        S_PKT = 1'b1
    } state_e;

    localparam int unsigned HDR_SEQ_W = 16;

    // The ispkt field sits at bit 0, so the busy field starts right after it.
    function automatic int unsigned hdr_busy_lsb(input int unsigned nch);
        return nch;
    endfunction

    // The sequence field occupies the top HDR_SEQ_W bits of the beat.
    function automatic int unsigned hdr_seq_lsb(input int unsigned out_w);
        return out_w - HDR_SEQ_W;
    endfunction

endpackage

// File: rtl/lowest_set_idx.sv
// Combinational priority encoder: index of the lowest set bit of vec_i.
//   vec_i   : input vector (N bits)
//   idx_o   : index of the lowest set bit (0 when none set)
//   found_o : 1 when at least one bit of vec_i is set
module lowest_set_idx #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    // Scan from the top down so the last hit, i.e. the lowest set bit, wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int unsigned i = N; i > 0; i--) begin
            if (vec_i[i-1]) begin
                idx_o   = IW'(i - 1);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rec_log_merger.sv
// Pops all channel record FIFOs in lock-step and serialises each record into
// one header beat plus one payload beat per channel carrying a real packet,
// in ascending channel order.
//   clk, rst   : clock; asynchronous active-high reset
//   rec_valid  : per-channel FIFO data valid
//   rec_ready  : per-channel FIFO pop (all bits identical)
//   ispkt_in   : per-channel "real packet" flag
//   busy_in    : per-channel busy flag
//   din        : per-channel payloads, channel i at [i*CH_WIDTH +: CH_WIDTH]
//   out_valid, out_ready, out_data, out_last : registered log beat stream
//   rec_cnt    : completed record count (wraps)
//   desync_err : sticky, set when rec_valid bits disagree
//   CNT_RST    : reset value of rec_cnt (0 in normal use)
module rec_log_merger
    import rec_log_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned CH_WIDTH  = 64,
    parameter int unsigned OUT_WIDTH = 128,
    parameter logic [31:0] CNT_RST   = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          rec_valid,
    output logic [NCH-1:0]          rec_ready,
    input  logic [NCH-1:0]          ispkt_in,
    input  logic [NCH-1:0]          busy_in,
    input  logic [NCH*CH_WIDTH-1:0] din,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic                    out_last,
    output logic [31:0]             rec_cnt,
    output logic                    desync_err
);

    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

    state_e                 state_q, state_d;
    logic [NCH-1:0]         pend_q, pend_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic [31:0]            rec_cnt_q, rec_cnt_d;
    logic                   desync_q, desync_d;

    logic                   all_valid;
    logic                   load;
    logic                   rec_done;
    logic [IW-1:0]          idx;
    logic                   found;
    logic [NCH-1:0]         pend_clr;
    logic [OUT_WIDTH-1:0]   hdr;
    logic [OUT_WIDTH-1:0]   pay;

    lowest_set_idx #(.N(NCH)) u_lsi (
        .vec_i   (pend_q),
        .idx_o   (idx),
        .found_o (found)
    );

    assign all_valid = &rec_valid;
    assign load      = !out_valid_q || out_ready;
    assign pend_clr  = found ? (pend_q & ~(NCH'(1) << idx)) : '0;

    always_comb begin
        hdr = '0;
        hdr[NCH-1:0]                                 = ispkt_in;
        hdr[hdr_busy_lsb(NCH) +: NCH]                = busy_in;
        hdr[hdr_seq_lsb(OUT_WIDTH) +: HDR_SEQ_W]     = rec_cnt_q[HDR_SEQ_W-1:0];
        pay = '0;
        pay[CH_WIDTH-1:0] = din[32'(idx) * CH_WIDTH +: CH_WIDTH];
    end

    // FIFO outputs are used in place; the pop is issued only in the cycle the
    // record's final beat is loaded, so din/ispkt/busy stay valid until then.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        rec_done    = 1'b0;
        if (load) begin
            unique case (state_q)
                S_HDR: begin
                    if (all_valid) begin
                        out_valid_d = 1'b1;
                        out_data_d  = hdr;
                        pend_d      = ispkt_in;
                        if (ispkt_in == '0) begin
                            out_last_d = 1'b1;
                            rec_done   = 1'b1;
                        end else begin
                            out_last_d = 1'b0;
                            state_d    = S_PKT;
                        end
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                    end
                end
                S_PKT: begin
                    out_valid_d = 1'b1;
                    out_data_d  = pay;
                    pend_d      = pend_clr;
                    if (pend_clr == '0) begin
                        out_last_d = 1'b1;
                        rec_done   = 1'b1;
                        state_d    = S_HDR;
                    end else begin
                        out_last_d = 1'b0;
                    end
                end
            endcase
        end
        rec_cnt_d = rec_cnt_q + 32'(rec_done);
        desync_d  = desync_q | ((|rec_valid) & ~all_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HDR;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            rec_cnt_q   <= CNT_RST;
            desync_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            rec_cnt_q   <= rec_cnt_d;
            desync_q    <= desync_d;
        end
    end

    // rec_done is combinational; mask it while reset is held so no pop leaks
    // out of a reset cycle.
    assign rec_ready  = {NCH{rec_done & ~rst}};
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_data   = out_data_q;
    assign rec_cnt    = rec_cnt_q;
    assign desync_err = desync_q;

endmodule
